// File: rtl/fpu_req_agent.sv
// Initiator-side agent for the lane-parallel FPU dispatcher.
// Allocates a free tag per issued request, keeps per-tag metadata, matches
// FPU responses by tag and presents one registered response to commit.
module fpu_req_agent #(
   parameter int NUM_THREADS = 4,
   parameter int TAGW        = 2,
   parameter int META_W      = 16
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [3:0]                req_op,
   input  logic [2:0]                req_frm,
   input  logic [NUM_THREADS*32-1:0] req_dataa,
   input  logic [NUM_THREADS*32-1:0] req_datab,
   input  logic [NUM_THREADS*32-1:0] req_datac,
   input  logic [META_W-1:0]         req_meta,

   output logic                      fpu_valid_in,
   input  logic                      fpu_ready_in,
   output logic [TAGW-1:0]           fpu_tag_in,
   output logic [3:0]                fpu_op_type,
   output logic [2:0]                fpu_frm,
   output logic [NUM_THREADS*32-1:0] fpu_dataa,
   output logic [NUM_THREADS*32-1:0] fpu_datab,
   output logic [NUM_THREADS*32-1:0] fpu_datac,

   input  logic                      fpu_valid_out,
   output logic                      fpu_ready_out,
   input  logic [TAGW-1:0]           fpu_tag_out,
   input  logic [NUM_THREADS*32-1:0] fpu_result,
   input  logic                      fpu_has_fflags,
   input  logic [NUM_THREADS-1:0]    fpu_fflags_NV,
   input  logic [NUM_THREADS-1:0]    fpu_fflags_DZ,
   input  logic [NUM_THREADS-1:0]    fpu_fflags_OF,
   input  logic [NUM_THREADS-1:0]    fpu_fflags_UF,
   input  logic [NUM_THREADS-1:0]    fpu_fflags_NX,

   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [META_W-1:0]         rsp_meta,
   output logic [NUM_THREADS*32-1:0] rsp_result,
   output logic                      rsp_has_fflags,
   output logic [4:0]                rsp_fflags,

   output logic [TAGW:0]             pending,
   output logic                      tag_err
);

   localparam int DEPTH = 1 << TAGW;

   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_next;
   logic [META_W-1:0] meta_table [DEPTH];
   logic [TAGW-1:0]   free_tag;
   logic              free_any;
   logic              alloc;
   logic              rsp_accept;
   logic              tag_hit;
   logic              capture;
   logic              drop;
   logic [4:0]        lane_flags;

   // Lowest-index free tag; scanning downward lets the lowest index win.
   always_comb begin
      free_tag = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy_q[i]) free_tag = TAGW'(i);
      end
   end

   assign free_any     = ~&busy_q;
   assign fpu_valid_in = req_valid & free_any;
   assign req_ready    = fpu_ready_in & free_any;
   assign fpu_tag_in   = free_tag;
   assign fpu_op_type  = req_op;
   assign fpu_frm      = req_frm;
   assign fpu_dataa    = req_dataa;
   assign fpu_datab    = req_datab;
   assign fpu_datac    = req_datac;

   assign alloc         = req_valid & req_ready;
   assign fpu_ready_out = ~rsp_valid | rsp_ready;
   assign rsp_accept    = fpu_valid_out & fpu_ready_out;
   assign tag_hit       = busy_q[fpu_tag_out];
   assign capture       = rsp_accept & tag_hit;
   assign drop          = rsp_accept & ~tag_hit;

   assign lane_flags = {5{fpu_has_fflags}} &
                       {|fpu_fflags_NV, |fpu_fflags_DZ, |fpu_fflags_OF,
                        |fpu_fflags_UF, |fpu_fflags_NX};

   // Bitmap update; allocation picks from the pre-edge bitmap, so the tag
   // being released this cycle can never be the one being allocated.
   always_comb begin
      busy_next = busy_q;
      if (capture) busy_next[fpu_tag_out] = 1'b0;
      if (alloc)   busy_next[free_tag]    = 1'b1;
   end

   // Busy bitmap and outstanding count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q  <= '0;
         pending <= '0;
      end else begin
         busy_q <= busy_next;
         case ({alloc, capture})
            2'b10:   pending <= pending + (TAGW+1)'(1);
            2'b01:   pending <= pending - (TAGW+1)'(1);
            default: pending <= pending;
         endcase
      end
   end

   // Metadata storage; only read back for tags that were written when allocated.
   always_ff @(posedge clk) begin
      if (alloc) meta_table[free_tag] <= req_meta;
   end

   // One-entry response register; capture and drain may share a cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid      <= 1'b0;
         rsp_meta       <= '0;
         rsp_result     <= '0;
         rsp_has_fflags <= 1'b0;
         rsp_fflags     <= '0;
      end else if (capture) begin
         rsp_valid      <= 1'b1;
         rsp_meta       <= meta_table[fpu_tag_out];
         rsp_result     <= fpu_result;
         rsp_has_fflags <= fpu_has_fflags;
         rsp_fflags     <= lane_flags;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   // Sticky error for responses carrying a tag that is not outstanding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    tag_err <= 1'b0;
      else if (drop) tag_err <= 1'b1;
   end

endmodule
